// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (8E1 when
// UART_TX_PARITY_EN is defined). The FSM pops a byte whenever the line
// is free, so queued bytes go out as contiguous frames with one stop bit.
// All outputs are registered; txd follows the FSM state one clock later.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD          = 12_000_000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          txd
);

    localparam int CLKS_PER_BIT = (CLK_FREQUENCY + BAUD / 2) / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, busy_q, txd_q, txd_d;
    logic                push_s, pop_s, bit_end_s, queued_s;

    // Handshake and per-bit timing strobes.
    always_comb begin
        push_s    = data_valid & ready_q;
        queued_s  = (count_q != {CNT_W{1'b0}});
        bit_end_s = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    end

    // Frame sequencing: pop when the line is free, then start/data/[parity]/stop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = {BAUD_W{1'b0}};
                if (queued_s) begin
                    pop_s     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(mem_q[rd_ptr_q]);
`endif
                    bit_cnt_d = 3'd0;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (queued_s) begin
                        // Next byte starts right after this stop bit: no idle gap.
                        pop_s     = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_d  = even_parity(mem_q[rd_ptr_q]);
`endif
                        bit_cnt_d = 3'd0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                baud_d  = {BAUD_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy update; push while full never reaches here because ready is low.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Line level for the state currently being held.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_q;
`endif
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase
    end

    // Transmitter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= {BAUD_W{1'b0}};
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage, pointers (wrap modulo depth) and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Registered pin-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            busy_q  <= (state_d != ST_IDLE) || (count_d != {CNT_W{1'b0}});
            txd_q   <= txd_d;
        end
    end

    assign data_ready = ready_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign txd        = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level line model compared
// every cycle, a behavioural serial decoder, and literal waveform checks.
module tb_uart_tx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [4:0] fifo_count;
    logic       busy;
    logic       txd;

    uart_tx_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit-slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Model: queue of waiting bytes plus the frame currently on the wire.
    logic [7:0] mq[$];
    logic [7:0] rxq[$];
    bit         m_act = 1'b0;
    int         m_s = 0;
    logic [7:0] m_byte = 8'h00;
    int         cyc = 0;
    logic       e_txd = 1'b1, e_busy = 1'b0, e_ready = 1'b1;
    int         e_cnt = 0;

    // Decoder state.
    logic          rx_prev = 1'b1;
    bit            rx_on = 1'b0;
    int            rx_t = 0;
    int            rx_got = 0;
    logic [NB-1:0] rx_bits;
    logic [7:0]    rx_exp;

    always @(posedge clk) begin : model
        int pre;
        bit push_m, pop_m;
        if (!reset_n) begin
            mq.delete();
            rxq.delete();
            m_act   = 1'b0;
            e_txd   = 1'b1;
            e_busy  = 1'b0;
            e_ready = 1'b1;
            e_cnt   = 0;
        end else begin
            cyc++;
            e_txd = 1'b1;
            if (m_act && (cyc - m_s) >= 1 && (cyc - m_s) <= FRAME)
                e_txd = frame_bit(m_byte, (cyc - m_s - 1) / CPB);
            pre    = mq.size();
            push_m = data_valid && (pre != DEPTH);
            pop_m  = (pre != 0) && (!m_act || (cyc - m_s) == FRAME);
            if (m_act && (cyc - m_s) == FRAME && !pop_m) m_act = 1'b0;
            if (pop_m) begin
                m_byte = mq.pop_front();
                m_s    = cyc;
                m_act  = 1'b1;
            end
            if (push_m) begin
                mq.push_back(data_in);
                rxq.push_back(data_in);
            end
            e_cnt   = mq.size();
            e_ready = (e_cnt != DEPTH);
            e_busy  = m_act || (e_cnt != 0);
        end
        #1;
        chk("txd", int'(txd), int'(e_txd));
        chk("busy", int'(busy), int'(e_busy));
        chk("data_ready", int'(data_ready), int'(e_ready));
        chk("fifo_count", int'(fifo_count), e_cnt);
        // Serial decoder: mid-bit sampling after each falling start edge.
        if (!reset_n) begin
            rx_on   = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_on && rx_prev && !txd) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
            if (rx_on) begin
                if ((rx_t % CPB) == CPB / 2) rx_bits[rx_t / CPB] = txd;
                if (rx_t == (NB - 1) * CPB + CPB / 2) begin
                    rx_on = 1'b0;
                    rx_got++;
                    chk("rx_start", int'(rx_bits[0]), 0);
                    chk("rx_stop", int'(rx_bits[NB-1]), 1);
                    if (rxq.size() == 0) begin
                        chk("rx_unexpected_frame", 1, 0);
                    end else begin
                        rx_exp = rxq.pop_front();
                        chk("rx_byte", int'(rx_bits[8:1]), int'(rx_exp));
`ifdef UART_TX_PARITY_EN
                        chk("rx_parity", int'(rx_bits[9]), int'(^rx_exp));
`endif
                    end
                end
                rx_t++;
            end
            rx_prev = txd;
        end
    end

    logic line [0:200];
    logic bz   [0:200];

    task automatic rec(input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            @(posedge clk);
            #2;
            line[k] = txd;
            bz[k]   = busy;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_act || mq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", n, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] a5_bits [8];
        int acc, thr;
        a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5 from idle.
        data_valid = 1'b1;
        data_in    = 8'hA5;
        @(negedge clk);
        data_valid = 1'b0;
        rec(1, FRAME + 4);
        chk("a5_idle_before_start", int'(line[1]), 1);
        chk("a5_start_at_n2", int'(line[2]), 0);
        for (int i = 0; i < 8; i++)
            chk("a5_data_bit", int'(line[2 + CPB * (i + 1) + 4]), int'(a5_bits[i]));
`ifdef UART_TX_PARITY_EN
        chk("a5_parity", int'(line[2 + CPB * 9 + 4]), 0);
`endif
        chk("a5_stop", int'(line[2 + CPB * (NB - 1) + 4]), 1);
        chk("a5_busy_last", int'(bz[FRAME]), 1);
        chk("a5_busy_drop", int'(bz[FRAME + 1]), 0);
        wait_idle(400);

        // 0x00 then 0xFF on consecutive cycles: contiguous frames.
        data_valid = 1'b1;
        data_in    = 8'h00;
        @(negedge clk);
        data_in    = 8'hFF;
        @(negedge clk);
        data_valid = 1'b0;
        rec(2, 2 * FRAME + 4);
        chk("b2b_first_bit0", int'(line[2 + CPB + 4]), 0);
        chk("b2b_first_stop_end", int'(line[FRAME + 1]), 1);
        chk("b2b_second_start", int'(line[FRAME + 2]), 0);
        chk("b2b_second_bit0", int'(line[FRAME + 2 + CPB + 4]), 1);
        chk("b2b_busy_last", int'(bz[2 * FRAME]), 1);
        chk("b2b_busy_drop", int'(bz[2 * FRAME + 1]), 0);
        wait_idle(400);

        // Valid held high: fill to 16 behind the first frame, then backpressure.
        data_valid = 1'b1;
        data_in    = 8'($urandom);
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #2;
            if (i == 16) begin
                chk("full_count", int'(fifo_count), 16);
                chk("full_ready", int'(data_ready), 0);
            end
            if (i == FRAME) chk("held_count", int'(fifo_count), 16);
            if (i == FRAME + 1) begin
                chk("pop_count", int'(fifo_count), 15);
                chk("pop_ready", int'(data_ready), 1);
            end
            if (i == FRAME + 2) chk("refill_count", int'(fifo_count), 16);
            @(negedge clk);
            data_in = 8'($urandom);
        end
        data_valid = 1'b0;
        wait_idle(3000);

        // Reset in the middle of 0x3C's data bits with five bytes queued.
        data_valid = 1'b1;
        data_in    = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_in = 8'($urandom);
        end
        @(negedge clk);
        data_valid = 1'b0;
        #1;
        chk("pre_reset_count", int'(fifo_count), 5);
        repeat (24) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_txd", int'(txd), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("post_rst_txd", int'(txd), 1);
        chk("post_rst_busy", int'(busy), 0);

        // 256 random bytes with random burstiness, decoded in order.
        rx_got = 0;
        acc    = 0;
        thr    = 5;
        for (int i = 0; i < 40000 && acc < 256; i++) begin
            @(negedge clk);
            if ((i % 64) == 0) thr = $urandom_range(1, 10);
            data_valid = ($urandom_range(0, 9) < thr);
            data_in    = 8'($urandom);
            if (data_valid && data_ready) acc++;
        end
        @(negedge clk);
        data_valid = 1'b0;
        chk("random_accepted", acc, 256);
        wait_idle(3000);
        chk("random_received", rx_got, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
